lcd_image_window: RTL and testbench

Parametrised LCD raster generator with a windowed image overlay for the Tang Nano 20K RGB panel. It produces HSYNC/VSYNC/DE from configurable porch and pulse widths and addresses an external synchronous ROM for a rectangular image window. The window has an integer pixel-replication scale and either 8-bit grayscale or RGB565 pixel format. Syncs and DE are pipelined to match the ROM read latency, so colour, DE and syncs leave the block cycle-aligned. The block sits between the PLL-derived pixel clock and the LCD pins and replaces the fixed-timing grayscale display block.

---
 rtl/lcd_image_window.sv | 105 ++++++++++
 tb/tb_lcd_image_window.sv | 109 ++++++++++
 2 files changed

// File: rtl/lcd_image_window.sv
// lcd_image_window: LCD raster timing with a ROM-addressed, integer-scaled image window overlay
module lcd_image_window #(
  parameter int H_SYNC = 1,
  parameter int H_BACK = 46,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT = 210,
  parameter int V_SYNC = 5,
  parameter int V_BACK = 0,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 45,
  parameter int IMG_X = 205,
  parameter int IMG_Y = 120,
  parameter int IMG_W = 390,
  parameter int IMG_H = 240,
  parameter int SCALE = 1,
  parameter int MODE = 0,
  parameter int ROM_LAT = 1,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input logic PixelClk,
  input logic Reset,
  output logic [ADDR_W-1:0] RomAddr,
  input logic [15:0] RomData,
  output logic FrameStart,
  output logic LCD_DE,
  output logic LCD_HSYNC,
  output logic LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int H0 = H_SYNC + H_BACK;
  localparam int V0 = V_SYNC + V_BACK;
  localparam int CW = $clog2(IMG_W + 1);
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0] hx, vy;
  logic h_end, v_end, de_raw, v_win, h_win, in_win;
  logic [CW-1:0] col;
  logic [1:0] sub_x, sub_y;
  logic [ADDR_W-1:0] row_base, addr_q, cur_addr;
  logic [4:0] raw, p;
  logic [4:0] pipe [ROM_LAT];
  logic [15:0] px;
  assign hx = 32'(hcnt);
  assign vy = 32'(vcnt);
  assign h_end = hx == H_TOTAL - 1;
  assign v_end = vy == V_TOTAL - 1;
  assign de_raw = hx >= H0 && hx < H0 + H_ACTIVE && vy >= V0 && vy < V0 + V_ACTIVE;
  assign v_win = vy >= V0 && vy < V0 + V_ACTIVE && vy >= V0 + IMG_Y && vy < V0 + IMG_Y + IMG_H*SCALE;
  assign h_win = hx >= H0 + IMG_X && hx < H0 + IMG_X + IMG_W*SCALE;
  assign in_win = de_raw && v_win && h_win;
  assign cur_addr = row_base + ADDR_W'(col);
  assign RomAddr = in_win ? cur_addr : addr_q;
  assign raw = {hcnt == '0 && vcnt == '0, in_win, de_raw, hx >= H_SYNC, vy >= V_SYNC};
  assign p = pipe[ROM_LAT-1];
  assign px = !p[2] ? 16'h0000 : !p[3] ? BG_COLOR : MODE != 0 ? RomData : {RomData[7:3], RomData[7:2], RomData[7:3]};
  always_ff @(posedge PixelClk)
    if (Reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_end ? '0 : hcnt + 1'b1;
      if (h_end) vcnt <= v_end ? '0 : vcnt + 1'b1;
    end
  always_ff @(posedge PixelClk)
    if (Reset) begin
      col <= '0;
      sub_x <= '0;
      sub_y <= '0;
      row_base <= '0;
      addr_q <= '0;
    end else begin
      col <= !in_win ? '0 : sub_x == 2'(SCALE - 1) ? col + 1'b1 : col;
      sub_x <= (!in_win || sub_x == 2'(SCALE - 1)) ? '0 : sub_x + 1'b1;
      if (in_win) addr_q <= cur_addr;
      if (h_end && v_end) begin
        row_base <= '0;
        sub_y <= '0;
      end else if (h_end && v_win) begin
        sub_y <= sub_y == 2'(SCALE - 1) ? '0 : sub_y + 1'b1;
        if (sub_y == 2'(SCALE - 1)) row_base <= row_base + ADDR_W'(IMG_W);
      end
    end
  always_ff @(posedge PixelClk)
    if (Reset) begin
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= 5'b00011;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  always_ff @(posedge PixelClk)
    if (Reset) begin
      {FrameStart, LCD_DE, LCD_HSYNC, LCD_VSYNC} <= 4'b0011;
      {LCD_R, LCD_G, LCD_B} <= 16'h0000;
    end else begin
      {FrameStart, LCD_DE, LCD_HSYNC, LCD_VSYNC} <= {p[4], p[2], p[1], p[0]};
      {LCD_R, LCD_G, LCD_B} <= px;
    end
endmodule

// File: tb/tb_lcd_image_window.sv
// tb_lcd_image_window: scoreboard checks of five lcd_image_window configurations on a small raster
module tb_lcd_image_window;
  localparam int N = 5;
  localparam int SC [N] = '{1, 2, 1, 1, 1};
  localparam int LT [N] = '{1, 1, 1, 3, 1};
  localparam int MD [N] = '{0, 0, 1, 0, 0};
  localparam int IX [N] = '{2, 0, 2, 2, 6};
  localparam int IY [N] = '{1, 0, 1, 1, 1};
  localparam logic [15:0] BG [N] = '{16'h0000, 16'h0000, 16'h07E0, 16'h0000, 16'h0000};
  typedef struct packed {
    logic fs;
    logic de;
    logic hs;
    logic vs;
    logic [15:0] rgb;
  } out_t;
  localparam out_t IDLE = '{fs: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 16'h0000};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int hm = 0;
  int vm = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    hm <= (rst || hm == 13) ? 0 : hm + 1;
    vm <= rst ? 0 : hm == 13 ? (vm == 9 ? 0 : vm + 1) : vm;
  end
  for (genvar k = 0; k < N; k++) begin : g
    logic [3:0] addr;
    logic [15:0] data;
    logic [3:0] rq [LT[k]];
    logic fs, de, hs, vs;
    logic [4:0] r, b;
    logic [5:0] gg;
    logic [3:0] hold = 4'd0;
    out_t q[$];
    lcd_image_window #(
      .H_SYNC(1), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(3),
      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(6), .V_FRONT(2),
      .IMG_X(IX[k]), .IMG_Y(IY[k]), .IMG_W(4), .IMG_H(3),
      .SCALE(SC[k]), .MODE(MD[k]), .ROM_LAT(LT[k]), .BG_COLOR(BG[k])
    ) dut (
      .PixelClk(clk), .Reset(rst), .RomAddr(addr), .RomData(data),
      .FrameStart(fs), .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
      .LCD_R(r), .LCD_G(gg), .LCD_B(b)
    );
    always @(posedge clk) begin
      rq[0] <= addr;
      for (int i = 1; i < LT[k]; i++) rq[i] <= rq[i-1];
    end
    assign data = MD[k] != 0 ? 16'hF81F : 16'(rq[LT[k]-1]) * 16'd17;
    always @(posedge clk) begin
      int ax, ay, ea;
      logic dee, win;
      logic [15:0] d, c;
      #1;
      ax = hm - 3;
      ay = vm - 2;
      dee = ax >= 0 && ax < 8 && ay >= 0 && ay < 6;
      win = dee && ax >= IX[k] && ax < IX[k] + 4*SC[k] && ay >= IY[k] && ay < IY[k] + 3*SC[k];
      ea = rst ? 0 : win ? (ay - IY[k]) / SC[k] * 4 + (ax - IX[k]) / SC[k] : int'(hold);
      d = MD[k] != 0 ? 16'hF81F : 16'(ea * 17);
      c = !dee ? 16'h0000 : !win ? BG[k] : MD[k] != 0 ? d : {d[7:3], d[7:2], d[7:3]};
      if (rst) begin
        q.delete();
        repeat (LT[k] + 1) q.push_back(IDLE);
      end
      checks++;
      if (addr !== 4'(ea)) begin
        failures++;
        if (failures <= 30) $display("FAIL cfg%0d rom_addr h=%0d v=%0d got=%0d want=%0d", k, hm, vm, addr, ea);
      end
      q.push_back('{fs: hm == 0 && vm == 0, de: dee, hs: hm >= 1, vs: vm >= 1, rgb: c});
      hold <= 4'(ea);
    end
    always @(negedge clk) begin
      out_t e, a;
      if (q.size() > LT[k] + 1) begin
        e = q.pop_front();
        a = '{fs: fs, de: de, hs: hs, vs: vs, rgb: {r, gg, b}};
        checks++;
        if (a !== e) begin
          failures++;
          if (failures <= 30)
            $display("FAIL cfg%0d pins h=%0d v=%0d got fs/de/hs/vs=%b%b%b%b rgb=%h want fs/de/hs/vs=%b%b%b%b rgb=%h",
                     k, hm, vm, a.fs, a.de, a.hs, a.vs, a.rgb, e.fs, e.de, e.hs, e.vs, e.rgb);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 140 && !(hm == 6 && vm == 4); i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (320) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (160) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
